// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   SEG_OFF    - all segments dark (active-low drive)
//   AN_OFF     - all anodes released, sized for the widest legal display
//   phase_t    - per-slot phase: dead time first, then drive
//   cnt_width  - register width needed to hold 0..n-1 (never less than 1)
package display_scan_ctrl_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0]            SEG_OFF = 7'h7F;
    localparam logic [MAX_DIGITS-1:0] AN_OFF  = '1;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Shared hex-to-seven-segment decoder for a common-anode display.
//   x     - nibble 0..F
//   seg_n - active-low segments, bit0 = a ... bit6 = g
module seven_seg_decoder (
    input  logic [3:0] x,
    output logic [6:0] seg_n
);

    logic [6:0] seg;   // active-high gfedcba

    always_comb begin
        seg = 7'h00;
        case (x)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    assign seg_n = ~seg;

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit common-anode display.
// Each digit slot is TICK_DIV cycles: BLANK_CYCLES of all-off dead time,
// then the rest driving one anode. New digits are latched into a shadow
// only at the frame boundary (last cycle of the last slot) so a frame never
// shows a mix of old and new data.
//   clk, rst_n   - clock, async active-low reset
//   digits_in    - nibbles, [3:0] = digit 0 (rightmost)
//   dp_in        - decimal point per digit
//   digit_en     - live per-digit enable
//   lz_blank     - live leading-zero suppression enable
//   update_req   - producer has new data, held until update_ack
//   update_ack   - one-cycle pulse after the boundary that loaded the shadow
//   dec_x/dec_seg- nibble out to / segments back from the external decoder
//   seg_n, dp_n, an_n - registered active-low display drive
//   frame_start  - one-cycle pulse as digit 0's slot begins
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic                    update_req,
    output logic                    update_ack,
    output logic [3:0]              dec_x,
    input  logic [6:0]              dec_seg,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);

    localparam int CW = cnt_width(TICK_DIV);
    localparam int IW = cnt_width(NUM_DIGITS);

    localparam logic [CW-1:0]         CNT_LAST   = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    phase_t        phase, phase_nxt;

    logic [NUM_DIGITS-1:0][3:0] shadow_digits;
    logic [NUM_DIGITS-1:0]      shadow_dp;

    logic slot_end, frame_end;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // ---------------- slot counter / digit index ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // ---------------- phase FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= BLANK;
        else        phase <= phase_nxt;
    end

    // BLANK_LAST < CNT_LAST always, so the two transitions never collide.
    always_comb begin
        phase_nxt = phase;
        case (phase)
            BLANK:   if (cnt == BLANK_LAST) phase_nxt = DRIVE;
            DRIVE:   if (slot_end)          phase_nxt = BLANK;
            default: phase_nxt = BLANK;
        endcase
    end

    // ---------------- shadow + handshake ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            update_ack    <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            frame_start <= frame_end;
            update_ack  <= frame_end && update_req;
            if (frame_end && update_req) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
            end
        end
    end

    // ---------------- suppression ----------------
    // zero_above[i] = shadow nibbles i..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS:0] zero_above;

    always_comb begin
        zero_above             = '0;
        zero_above[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            zero_above[i] = zero_above[i+1] & ~|shadow_digits[i];
    end

    logic suppressed;
    assign suppressed = !digit_en[idx] ||
                        (lz_blank && (idx != '0) && zero_above[idx]);

    assign dec_x = shadow_digits[idx];

    // ---------------- registered drive ----------------
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    always_comb begin
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        an_nxt  = AN_ALL_OFF;
        if (phase == DRIVE && !suppressed) begin
            an_nxt[idx] = 1'b0;
            seg_nxt     = dec_seg;
            dp_nxt      = ~shadow_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= SEG_OFF;
            dp_n  <= 1'b1;
            an_n  <= AN_ALL_OFF;
        end else begin
            seg_n <= seg_nxt;
            dp_n  <= dp_nxt;
            an_n  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles).
// Stimulus queues one expected frame per update; a monitor pops it when the
// DUT opens a frame (frame_start, with update_ack for loads) and samples each
// slot mid-blank and mid-drive.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = 4'hF;
    logic        lz_blank = 1'b0;
    logic        update_req = 1'b0;
    logic        update_ack;
    logic [3:0]  dec_x;
    logic [6:0]  dec_seg;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit              need_ack;
        logic [3:0]      on;
        logic [3:0][6:0] seg;
        logic [3:0]      dp_n;
    } frame_exp_t;

    frame_exp_t exp_q[$];

    always #5 clk = ~clk;

    display_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .digit_en(digit_en), .lz_blank(lz_blank), .update_req(update_req),
        .update_ack(update_ack), .dec_x(dec_x), .dec_seg(dec_seg),
        .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_start(frame_start)
    );

    seven_seg_decoder u_dec (.x(dec_x), .seg_n(dec_seg));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic frame_exp_t mk(input bit ack, input logic [3:0] on,
                                      input logic [3:0][6:0] seg, input logic [3:0] dpn);
        frame_exp_t e;
        e.need_ack = ack;
        e.on       = on;
        e.seg      = seg;
        e.dp_n     = dpn;
        return e;
    endfunction

    // Walks one frame starting from the frame_start cycle (offset 0).
    task automatic check_frame(input frame_exp_t e);
        logic [3:0] ea;
        int s;
        for (int off = 1; off < 32; off++) begin
            @(negedge clk);
            if (!rst_n) return;
            s = off / 8;
            if (off % 8 == 2) begin
                chk($sformatf("blank_an_s%0d", s), 32'(an_n), 32'hF);
                chk($sformatf("blank_seg_s%0d", s), 32'(seg_n), 32'h7F);
            end
            if (off % 8 == 5) begin
                ea = 4'hF;
                if (e.on[s]) ea[s] = 1'b0;
                chk($sformatf("drive_an_s%0d", s), 32'(an_n), 32'(ea));
                chk($sformatf("drive_seg_s%0d", s), 32'(seg_n),
                    32'(e.on[s] ? e.seg[s] : 7'h7F));
                chk($sformatf("drive_dp_s%0d", s), 32'(dp_n),
                    32'(e.on[s] ? e.dp_n[s] : 1'b1));
            end
        end
    endtask

    // Frame monitor / scoreboard consumer
    initial begin
        frame_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && frame_start) begin
                if (update_ack) begin
                    if (exp_q.size() == 0 || !exp_q[0].need_ack) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: update_ack=1 with no load expected (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check_frame(e);
                    end
                end else if (exp_q.size() != 0 && !exp_q[0].need_ack) begin
                    e = exp_q.pop_front();
                    check_frame(e);
                end
            end
        end
    end

    // Per-cycle invariants
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("an_overlap", 32'($countones(~an_n) > 1), 32'd0);
                if (update_ack && !frame_start) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_off_boundary: update_ack=1 while frame_start=0 (t=%0t)", $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Raise req, wait (bounded) for ack, then hold inputs through the frame.
    task automatic load_frame(input logic [15:0] d, input logic [3:0] dp,
                              input logic [3:0] en, input logic lzv, input frame_exp_t e);
        int n;
        digits_in  = d;
        dp_in      = dp;
        digit_en   = en;
        lz_blank   = lzv;
        update_req = 1'b1;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!update_ack && n < 80);
        chk("load_ack_seen", 32'(update_ack), 32'd1);
        update_req = 1'b0;
        repeat (31) @(negedge clk);
    endtask

    initial begin
        int n;
        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an_n), 32'hF);
        chk("rst_seg", 32'(seg_n), 32'h7F);
        chk("rst_dp", 32'(dp_n), 32'd1);
        chk("rst_ack", 32'(update_ack), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);

        // ---- release: blank 3 cycles, digit 0 for 6; req at cycle 5 -> ack at 32 ----
        rst_n = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 5) begin
                digits_in  = 16'h8888;
                update_req = 1'b1;
                exp_q.push_back(mk(1'b1, 4'hF, {7'h00, 7'h00, 7'h00, 7'h00}, 4'hF));
            end
            if (k <= 9) begin
                chk($sformatf("startup_an_k%0d", k), 32'(an_n),
                    (k >= 3 && k <= 8) ? 32'hE : 32'hF);
                chk($sformatf("startup_seg_k%0d", k), 32'(seg_n),
                    (k >= 3 && k <= 8) ? 32'h40 : 32'h7F);
            end
            chk($sformatf("ack_timing_k%0d", k), 32'(update_ack), (k == 32) ? 32'd1 : 32'd0);
        end
        chk("ack_with_fs", 32'(frame_start), 32'd1);
        update_req = 1'b0;
        repeat (31) @(negedge clk);

        // ---- leading-zero suppression ----
        load_frame(16'h0005, 4'h0, 4'hF, 1'b1,
                   mk(1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'hF));
        load_frame(16'h0000, 4'h0, 4'hF, 1'b1,
                   mk(1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF));
        load_frame(16'h0105, 4'h0, 4'hF, 1'b1,
                   mk(1'b1, 4'b0111, {7'h7F, 7'h79, 7'h40, 7'h12}, 4'hF));

        // ---- digit enable and decimal point ----
        load_frame(16'h8888, 4'b0010, 4'b1011, 1'b0,
                   mk(1'b1, 4'b1011, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b1101));

        // ---- req pulse that misses the boundary: shadow keeps 8888 ----
        @(negedge clk);
        digit_en = 4'hF;
        repeat (10) @(negedge clk);
        digits_in  = 16'h1111;
        update_req = 1'b1;
        repeat (10) @(negedge clk);
        update_req = 1'b0;
        exp_q.push_back(mk(1'b0, 4'hF, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b1101));
        repeat (11) @(negedge clk);
        repeat (32) @(negedge clk);

        // ---- reset mid-slot (idx 2, cnt 4) with req pending ----
        @(negedge clk);
        repeat (2) @(negedge clk);
        digits_in  = 16'h4321;
        dp_in      = 4'b0001;
        update_req = 1'b1;
        exp_q.push_back(mk(1'b1, 4'hF, {7'h19, 7'h30, 7'h24, 7'h79}, 4'b1110));
        repeat (18) @(negedge clk);
        chk("pre_rst_an", 32'(an_n), 32'hB);
        rst_n = 1'b0;
        #1;
        chk("midrst_an", 32'(an_n), 32'hF);
        chk("midrst_seg", 32'(seg_n), 32'h7F);
        chk("midrst_dp", 32'(dp_n), 32'd1);
        chk("midrst_ack", 32'(update_ack), 32'd0);
        chk("midrst_decx", 32'(dec_x), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!update_ack && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_ack_cycle", 32'(n), 32'd32);
        chk("post_rst_fs", 32'(frame_start), 32'd1);
        update_req = 1'b0;
        repeat (33) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
